// File: rtl/plane_sample_scheduler_if.sv
// Bundle between the RANSAC sample scheduler, point memory, derive_plane and the plane consumer.
interface plane_sample_scheduler_if #(
    parameter int index_width  = 10,
    parameter int iter_width   = 16,
    parameter int point_width  = 96,
    parameter int normal_width = 96,
    parameter int scalar_width = 32,
    parameter int status_width = 2
);
    logic [index_width-1:0]  mem_raddr;
    logic [point_width-1:0]  mem_rdata;
    logic                    dp_ivalid;
    logic                    dp_iready;
    logic [point_width-1:0]  dp_a;
    logic [point_width-1:0]  dp_b;
    logic [point_width-1:0]  dp_c;
    logic                    dp_ovalid;
    logic                    dp_oacknowledge;
    logic [normal_width-1:0] dp_n;
    logic [scalar_width-1:0] dp_d;
    logic [status_width-1:0] dp_status;
    logic                    plane_valid;
    logic                    plane_ready;
    logic [normal_width-1:0] plane_n;
    logic [scalar_width-1:0] plane_d;
    logic [iter_width-1:0]   plane_index;

    modport master (
        output mem_raddr, dp_ivalid, dp_a, dp_b, dp_c, dp_oacknowledge,
               plane_valid, plane_n, plane_d, plane_index,
        input  mem_rdata, dp_iready, dp_ovalid, dp_n, dp_d, dp_status, plane_ready
    );

    modport slave (
        input  mem_raddr, dp_ivalid, dp_a, dp_b, dp_c, dp_oacknowledge,
               plane_valid, plane_n, plane_d, plane_index,
        output mem_rdata, dp_iready, dp_ovalid, dp_n, dp_d, dp_status, plane_ready
    );
endinterface

// File: rtl/plane_sample_scheduler.sv
// RANSAC hypothesis sequencer: draws three distinct LFSR indices, fetches the points,
// runs derive_plane, resamples degenerate triples and streams successful planes downstream.
//
//   state  | meaning
//   IDLE   | waiting for start
//   DRAW   | one LFSR candidate per cycle until three distinct in-range indices are held
//   FETCH  | read idx0..idx2 from point memory, capture into dp_a/b/c
//   ISSUE  | dp_ivalid high until derive_plane accepts
//   WAIT   | waiting for derive_plane result
//   EMIT   | plane_valid high until downstream accepts
//   FINISH | one-cycle done pulse
module plane_sample_scheduler #(
    parameter int                      index_width    = 10,
    parameter int                      iter_width     = 16,
    parameter logic [15:0]             lfsr_seed      = 16'hACE1,
    parameter int                      max_retries    = 4,
    parameter int                      point_width    = 96,
    parameter int                      normal_width   = 96,
    parameter int                      scalar_width   = 32,
    parameter int                      status_width   = 2,
    parameter logic [status_width-1:0] status_success = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [index_width-1:0] point_count_i,
    input  logic [iter_width-1:0]  iterations_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [iter_width-1:0]  skipped_count_o,
    plane_sample_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_DRAW, S_FETCH, S_ISSUE, S_WAIT, S_EMIT, S_FINISH
    } state_e;

    localparam logic [15:0] lfsr_init = (lfsr_seed == 16'h0000) ? 16'h0001 : lfsr_seed;

    state_e                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [index_width-1:0]  pc_q, pc_d;
    logic [iter_width-1:0]   budget_q, budget_d;
    logic [iter_width-1:0]   iter_q, iter_d;
    logic [7:0]              retry_q, retry_d;
    logic [iter_width-1:0]   skipped_q, skipped_d;
    logic                    error_q, error_d;
    logic [1:0]              draw_cnt_q, draw_cnt_d;
    logic [1:0]              fetch_cnt_q, fetch_cnt_d;
    logic [index_width-1:0]  idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d;
    logic [point_width-1:0]  dp_a_q, dp_a_d, dp_b_q, dp_b_d, dp_c_q, dp_c_d;
    logic [normal_width-1:0] plane_n_q, plane_n_d;
    logic [scalar_width-1:0] plane_d_q, plane_d_d;
    logic [iter_width-1:0]   plane_index_q, plane_index_d;

    logic [index_width-1:0]  cand;
    logic                    cand_ok;
    logic [iter_width-1:0]   iter_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            lfsr_q        <= lfsr_init;
            pc_q          <= '0;
            budget_q      <= '0;
            iter_q        <= '0;
            retry_q       <= '0;
            skipped_q     <= '0;
            error_q       <= 1'b0;
            draw_cnt_q    <= '0;
            fetch_cnt_q   <= '0;
            idx0_q        <= '0;
            idx1_q        <= '0;
            idx2_q        <= '0;
            dp_a_q        <= '0;
            dp_b_q        <= '0;
            dp_c_q        <= '0;
            plane_n_q     <= '0;
            plane_d_q     <= '0;
            plane_index_q <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            pc_q          <= pc_d;
            budget_q      <= budget_d;
            iter_q        <= iter_d;
            retry_q       <= retry_d;
            skipped_q     <= skipped_d;
            error_q       <= error_d;
            draw_cnt_q    <= draw_cnt_d;
            fetch_cnt_q   <= fetch_cnt_d;
            idx0_q        <= idx0_d;
            idx1_q        <= idx1_d;
            idx2_q        <= idx2_d;
            dp_a_q        <= dp_a_d;
            dp_b_q        <= dp_b_d;
            dp_c_q        <= dp_c_d;
            plane_n_q     <= plane_n_d;
            plane_d_q     <= plane_d_d;
            plane_index_q <= plane_index_d;
        end
    end

    // A candidate must be in range and differ from every index already held for this sample.
    assign cand     = lfsr_q[index_width-1:0];
    assign cand_ok  = (cand < pc_q)
                   && !((draw_cnt_q != 2'd0) && (cand == idx0_q))
                   && !((draw_cnt_q == 2'd2) && (cand == idx1_q));
    assign iter_inc = (iter_q == '1) ? iter_q : iter_q + iter_width'(1);

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        pc_d          = pc_q;
        budget_d      = budget_q;
        iter_d        = iter_q;
        retry_d       = retry_q;
        skipped_d     = skipped_q;
        error_d       = error_q;
        draw_cnt_d    = draw_cnt_q;
        fetch_cnt_d   = fetch_cnt_q;
        idx0_d        = idx0_q;
        idx1_d        = idx1_q;
        idx2_d        = idx2_q;
        dp_a_d        = dp_a_q;
        dp_b_d        = dp_b_q;
        dp_c_d        = dp_c_q;
        plane_n_d     = plane_n_q;
        plane_d_d     = plane_d_q;
        plane_index_d = plane_index_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    pc_d       = point_count_i;
                    budget_d   = iterations_i;
                    iter_d     = '0;
                    retry_d    = '0;
                    skipped_d  = '0;
                    error_d    = 1'b0;
                    draw_cnt_d = '0;
                    if (point_count_i < index_width'(3)) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else if (iterations_i == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                if (cand_ok) begin
                    case (draw_cnt_q)
                        2'd0: begin
                            idx0_d     = cand;
                            draw_cnt_d = 2'd1;
                        end
                        2'd1: begin
                            idx1_d     = cand;
                            draw_cnt_d = 2'd2;
                        end
                        default: begin
                            idx2_d      = cand;
                            draw_cnt_d  = 2'd0;
                            fetch_cnt_d = 2'd0;
                            state_d     = S_FETCH;
                        end
                    endcase
                end
            end
            S_FETCH: begin
                // Read data lags the address by one cycle, so capture trails the address phase.
                fetch_cnt_d = fetch_cnt_q + 2'd1;
                case (fetch_cnt_q)
                    2'd1:    dp_a_d = bus.mem_rdata;
                    2'd2:    dp_b_d = bus.mem_rdata;
                    2'd3: begin
                        dp_c_d  = bus.mem_rdata;
                        state_d = S_ISSUE;
                    end
                    default: ;
                endcase
            end
            S_ISSUE: begin
                if (bus.dp_iready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.dp_ovalid) begin
                    if (bus.dp_status == status_success) begin
                        plane_n_d     = bus.dp_n;
                        plane_d_d     = bus.dp_d;
                        plane_index_d = iter_q;
                        retry_d       = '0;
                        state_d       = S_EMIT;
                    end else if (retry_q < 8'(max_retries)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_DRAW;
                    end else begin
                        skipped_d = (skipped_q == '1) ? skipped_q : skipped_q + iter_width'(1);
                        retry_d   = '0;
                        iter_d    = iter_inc;
                        state_d   = (iter_inc == budget_q) ? S_FINISH : S_DRAW;
                    end
                end
            end
            S_EMIT: begin
                if (bus.plane_ready) begin
                    iter_d  = iter_inc;
                    state_d = (iter_inc == budget_q) ? S_FINISH : S_DRAW;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_raddr = '0;
        if (state_q == S_FETCH) begin
            case (fetch_cnt_q)
                2'd0:    bus.mem_raddr = idx0_q;
                2'd1:    bus.mem_raddr = idx1_q;
                2'd2:    bus.mem_raddr = idx2_q;
                default: bus.mem_raddr = '0;
            endcase
        end
    end

    assign busy_o              = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done_o              = (state_q == S_FINISH);
    assign error_o             = error_q;
    assign skipped_count_o     = skipped_q;
    assign bus.dp_ivalid       = (state_q == S_ISSUE);
    assign bus.dp_oacknowledge = (state_q == S_WAIT) && bus.dp_ovalid;
    assign bus.dp_a            = dp_a_q;
    assign bus.dp_b            = dp_b_q;
    assign bus.dp_c            = dp_c_q;
    assign bus.plane_valid     = (state_q == S_EMIT);
    assign bus.plane_n         = plane_n_q;
    assign bus.plane_d         = plane_d_q;
    assign bus.plane_index     = plane_index_q;
endmodule
